byte_serial_mem_bridge: RTL and testbench

- Parametrised word-to-byte memory access unit between the datapath and the byte-wide Memory block.
- Replaces the fixed single-byte MuxC path and the LH-selected byte loading: one request moves a full DATA_WIDTH word over DATA_WIDTH/8 consecutive memory cycles.
- Reads reassemble the word; writes split it. Byte order is little-endian.

---
 rtl/byte_serial_mem_bridge.sv | 164 ++++++++++++++++
 tb/tb_byte_serial_mem_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_mem_bridge
//  Description : Moves one DATA_WIDTH word to or from a byte-wide memory over
//                DATA_WIDTH/8 consecutive memory cycles, little-endian.
//                Reads reassemble the word into RData; writes split WData.
//                Optional macro BRIDGE_ALIGN_CHECK_EN rejects requests whose
//                base address is not a multiple of the word size in bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_mem_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WData,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [7:0]            Mem_Data,
    input  logic [7:0]            Mem_In,
    output logic                  Mem_CS,
    output logic                  Mem_WR
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_CNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BYTES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_CNT_W-1:0]    r_beat;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wshift;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cs;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_data;

    logic w_accept;
    logic w_misaligned;
    logic w_start;
    logic w_last;

    // The edge closing DONE is treated like an IDLE edge so a held Start
    // launches the next transfer with no idle bubble.
    assign w_accept = Start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_beat == c_LAST);
    assign w_start  = w_accept && !w_misaligned;

`ifdef BRIDGE_ALIGN_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] c_BYTES_A = ADDR_WIDTH'(c_BYTES);

    logic r_error;

    assign w_misaligned = ((Addr % c_BYTES_A) != '0);

    // Rejected request: pulse Error for one cycle, no memory activity.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_accept && w_misaligned;
        end
    end

    assign Error = r_error;
`else
    assign w_misaligned = 1'b0;
    assign Error        = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next_state = c_XFER;
            c_XFER:  if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = w_start ? c_XFER : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Beat sequencing, registered memory-side outputs and read assembly.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_beat   <= '0;
            r_write  <= 1'b0;
            r_wshift <= '0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cs     <= 1'b1;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_XFER) begin
                if (!r_write) begin
                    for (int b = 0; b < c_BYTES; b++) begin
                        if (r_beat == c_CNT_W'(b)) begin
                            r_rdata[8*b +: 8] <= Mem_In;
                        end
                    end
                end
                if (w_last) begin
                    r_cs   <= 1'b1;
                    r_done <= 1'b1;
                end else begin
                    r_beat   <= r_beat + 1'b1;
                    r_addr   <= r_addr + 1'b1;
                    r_data   <= r_wshift[7:0];
                    r_wshift <= r_wshift >> 8;
                end
            end
            if (w_start) begin
                // Beat 0 is presented in the cycle right after the Start edge.
                r_busy   <= 1'b1;
                r_cs     <= 1'b0;
                r_wr     <= Write;
                r_write  <= Write;
                r_addr   <= Addr;
                r_data   <= WData[7:0];
                r_wshift <= WData >> 8;
                r_beat   <= '0;
            end else if (r_state == c_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign RData       = r_rdata;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Mem_Address = r_addr;
    assign Mem_Data    = r_data;
    assign Mem_CS      = r_cs;
    assign Mem_WR      = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_mem_bridge
//  Description : Directed bench for byte_serial_mem_bridge: a 16-bit and a
//                32-bit instance, each attached to a 64 KiB byte memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        start_a, write_a;
    logic [15:0] addr_a, wdata_a, rdata_a, mem_addr_a;
    logic        busy_a, done_a, error_a, cs_a, wr_a;
    logic [7:0]  mem_data_a, mem_in_a;

    logic        start_b, write_b;
    logic [15:0] addr_b, mem_addr_b;
    logic [31:0] wdata_b, rdata_b;
    logic        busy_b, done_b, error_b, cs_b, wr_b;
    logic [7:0]  mem_data_b, mem_in_b;

    logic [7:0]  mem_a [0:65535];
    logic [7:0]  mem_b [0:65535];

    int vectors = 0;
    int errors  = 0;

    byte_serial_mem_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) u_dut_a (
        .Clock(clk), .Reset(rst), .Start(start_a), .Write(write_a),
        .Addr(addr_a), .WData(wdata_a), .RData(rdata_a), .Busy(busy_a),
        .Done(done_a), .Error(error_a), .Mem_Address(mem_addr_a),
        .Mem_Data(mem_data_a), .Mem_In(mem_in_a), .Mem_CS(cs_a), .Mem_WR(wr_a)
    );

    byte_serial_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) u_dut_b (
        .Clock(clk), .Reset(rst), .Start(start_b), .Write(write_b),
        .Addr(addr_b), .WData(wdata_b), .RData(rdata_b), .Busy(busy_b),
        .Done(done_b), .Error(error_b), .Mem_Address(mem_addr_b),
        .Mem_Data(mem_data_b), .Mem_In(mem_in_b), .Mem_CS(cs_b), .Mem_WR(wr_b)
    );

    assign mem_in_a = mem_a[mem_addr_a];
    assign mem_in_b = mem_b[mem_addr_b];

    always @(posedge clk) if (!cs_a && wr_a) mem_a[mem_addr_a] <= mem_data_a;
    always @(posedge clk) if (!cs_b && wr_b) mem_b[mem_addr_b] <= mem_data_b;

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; write_a = 1'b0; addr_a = 16'h0; wdata_a = 16'h0;
        start_b = 1'b0; write_b = 1'b0; addr_b = 16'h0; wdata_b = 32'h0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        vectors++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
        vectors++; if (error_a !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error_a); end
        vectors++; if (rdata_a !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata_a); end
        vectors++; if (cs_a !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", cs_a); end
        vectors++; if (wr_a !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr_a); end
        vectors++; if (mem_addr_a !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr_a); end
        vectors++; if (mem_data_a !== 8'h0) begin errors++; $display("FAIL reset_mdata: got %h want 00", mem_data_a); end
        vectors++; if (cs_b !== 1'b1) begin errors++; $display("FAIL reset_cs_b: got %b want 1", cs_b); end
        vectors++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL reset_rdata_b: got %h want 0", rdata_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        logic [7:0] exp_byte [2];
        exp_byte[0] = 8'hCD; exp_byte[1] = 8'hAB;
        start_a = 1'b1; write_a = 1'b1; addr_a = 16'h0010; wdata_a = 16'hABCD;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++; if (cs_a !== (c >= 2)) begin errors++; $display("FAIL wr_cs[%0d]: got %b want %b", c, cs_a, (c >= 2)); end
            vectors++; if (busy_a !== (c < 3)) begin errors++; $display("FAIL wr_busy[%0d]: got %b want %b", c, busy_a, (c < 3)); end
            vectors++; if (done_a !== (c == 2)) begin errors++; $display("FAIL wr_done[%0d]: got %b want %b", c, done_a, (c == 2)); end
            if (c < 2) begin
                vectors++; if (wr_a !== 1'b1) begin errors++; $display("FAIL wr_we[%0d]: got %b want 1", c, wr_a); end
                vectors++; if (mem_addr_a !== 16'h0010 + 16'(c)) begin errors++; $display("FAIL wr_addr[%0d]: got %h want %h", c, mem_addr_a, 16'h0010 + 16'(c)); end
                vectors++; if (mem_data_a !== exp_byte[c]) begin errors++; $display("FAIL wr_data[%0d]: got %h want %h", c, mem_data_a, exp_byte[c]); end
            end
            if (c < 3) @(negedge clk);
        end
        vectors++; if (mem_a[16'h0010] !== 8'hCD) begin errors++; $display("FAIL wr_mem10: got %h want cd", mem_a[16'h0010]); end
        vectors++; if (mem_a[16'h0011] !== 8'hAB) begin errors++; $display("FAIL wr_mem11: got %h want ab", mem_a[16'h0011]); end
    endtask

    task automatic test_read_hold();
        int cyc;
        start_a = 1'b1; write_a = 1'b0; addr_a = 16'h0010;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_a) break;
            @(negedge clk);
            cyc++;
        end
        vectors++; if (done_a !== 1'b1 || cyc != 2) begin errors++; $display("FAIL rd_done_at: got done=%b cycle %0d want done=1 cycle 2", done_a, cyc); end
        vectors++; if (rdata_a !== 16'hABCD) begin errors++; $display("FAIL rd_data: got %h want abcd", rdata_a); end
        @(negedge clk);
        start_a = 1'b1; write_a = 1'b1; addr_a = 16'h0020; wdata_a = 16'h1234;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        vectors++; if (done_a !== 1'b1) begin errors++; $display("FAIL rd_wr_timeout: got done=%b want 1", done_a); end
        vectors++; if (rdata_a !== 16'hABCD) begin errors++; $display("FAIL rd_hold: got %h want abcd", rdata_a); end
        vectors++; if (mem_a[16'h0020] !== 8'h34 || mem_a[16'h0021] !== 8'h12) begin errors++; $display("FAIL rd_wr_mem: got %h%h want 1234", mem_a[16'h0021], mem_a[16'h0020]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cs_low, dn;
        mem_a[16'h0040] = 8'h5A; mem_a[16'h0041] = 8'hA5;
        cs_low = 0; dn = 0;
        start_a = 1'b1; write_a = 1'b0; addr_a = 16'h0040;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (!cs_a) cs_low++;
            if (done_a) dn++;
            if (c == 2) begin
                vectors++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", done_a); end
            end
            if (c == 3) begin
                vectors++; if (cs_a !== 1'b0 || mem_addr_a !== 16'h0040) begin errors++; $display("FAIL b2b_restart: got cs=%b addr=%h want cs=0 addr=0040", cs_a, mem_addr_a); end
                start_a = 1'b0;
            end
        end
        vectors++; if (cs_low != 4) begin errors++; $display("FAIL b2b_cs_low: got %0d want 4", cs_low); end
        vectors++; if (dn != 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 2", dn); end
        vectors++; if (rdata_a !== 16'hA55A) begin errors++; $display("FAIL b2b_rdata: got %h want a55a", rdata_a); end
        vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid();
        int dn, csl;
        mem_a[16'h0050] = 8'hEF; mem_a[16'h0051] = 8'hBE;
        start_a = 1'b1; write_a = 1'b0; addr_a = 16'h0050;
        @(negedge clk);
        start_a = 1'b0;
        vectors++; if (cs_a !== 1'b0 || mem_addr_a !== 16'h0050) begin errors++; $display("FAIL rm_beat0: got cs=%b addr=%h want cs=0 addr=0050", cs_a, mem_addr_a); end
        @(negedge clk);
        vectors++; if (rdata_a !== 16'hA5EF) begin errors++; $display("FAIL rm_partial: got %h want a5ef", rdata_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (cs_a !== 1'b1) begin errors++; $display("FAIL rm_cs: got %b want 1", cs_a); end
        vectors++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy_a); end
        vectors++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL rm_rdata: got %h want 0000", rdata_a); end
        dn = 0; csl = 0;
        for (int c = 0; c < 4; c++) begin
            if (done_a) dn++;
            if (!cs_a) csl++;
            @(negedge clk);
        end
        vectors++; if (dn != 0) begin errors++; $display("FAIL rm_no_done: got %0d want 0", dn); end
        vectors++; if (csl != 0) begin errors++; $display("FAIL rm_no_cycles: got %0d want 0", csl); end
    endtask

    task automatic test_align();
        mem_a[16'h0012] = 8'h77; mem_a[16'h0013] = 8'h66;
`ifdef BRIDGE_ALIGN_CHECK_EN
        start_a = 1'b1; write_a = 1'b0; addr_a = 16'h0011;
        @(negedge clk);
        vectors++; if (error_a !== 1'b1) begin errors++; $display("FAIL al_error: got %b want 1", error_a); end
        vectors++; if (cs_a !== 1'b1) begin errors++; $display("FAIL al_cs: got %b want 1", cs_a); end
        vectors++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL al_busy_done: got %b%b want 00", busy_a, done_a); end
        vectors++; if (rdata_a !== 16'h0000) begin errors++; $display("FAIL al_rdata_kept: got %h want 0000", rdata_a); end
        addr_a = 16'h0012;
        @(negedge clk);
        start_a = 1'b0;
        vectors++; if (error_a !== 1'b0) begin errors++; $display("FAIL al_error_clr: got %b want 0", error_a); end
        vectors++; if (cs_a !== 1'b0 || mem_addr_a !== 16'h0012) begin errors++; $display("FAIL al_accept: got cs=%b addr=%h want cs=0 addr=0012", cs_a, mem_addr_a); end
        for (int i = 0; i < 8; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        vectors++; if (done_a !== 1'b1) begin errors++; $display("FAIL al_timeout: got done=%b want 1", done_a); end
        vectors++; if (rdata_a !== 16'h6677) begin errors++; $display("FAIL al_rdata: got %h want 6677", rdata_a); end
`else
        start_a = 1'b1; write_a = 1'b0; addr_a = 16'h0011;
        @(negedge clk);
        start_a = 1'b0;
        vectors++; if (error_a !== 1'b0) begin errors++; $display("FAIL al_error: got %b want 0", error_a); end
        vectors++; if (cs_a !== 1'b0 || mem_addr_a !== 16'h0011) begin errors++; $display("FAIL al_accept: got cs=%b addr=%h want cs=0 addr=0011", cs_a, mem_addr_a); end
        for (int i = 0; i < 8; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        vectors++; if (done_a !== 1'b1) begin errors++; $display("FAIL al_timeout: got done=%b want 1", done_a); end
        vectors++; if (rdata_a !== 16'h77AB) begin errors++; $display("FAIL al_rdata: got %h want 77ab", rdata_a); end
`endif
        @(negedge clk);
    endtask

    task automatic test_wrap_32();
        logic [15:0] exp_addr [4];
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        start_b = 1'b1; write_b = 1'b1; addr_b = 16'hFFFE; wdata_b = 32'h11223344;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++; if (cs_b !== 1'b0 || mem_addr_b !== exp_addr[c]) begin errors++; $display("FAIL wrap_beat[%0d]: got cs=%b addr=%h want cs=0 addr=%h", c, cs_b, mem_addr_b, exp_addr[c]); end
            @(negedge clk);
        end
        vectors++; if (done_b !== 1'b1 || error_b !== 1'b0) begin errors++; $display("FAIL wrap_done: got done=%b err=%b want done=1 err=0", done_b, error_b); end
        @(negedge clk);
        vectors++; if (mem_b[16'hFFFE] !== 8'h44 || mem_b[16'hFFFF] !== 8'h33 || mem_b[16'h0000] !== 8'h22 || mem_b[16'h0001] !== 8'h11)
            begin errors++; $display("FAIL wrap_mem: got %h %h %h %h want 44 33 22 11", mem_b[16'hFFFE], mem_b[16'hFFFF], mem_b[16'h0000], mem_b[16'h0001]); end
        start_b = 1'b1; write_b = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_b) break;
            @(negedge clk);
        end
        vectors++; if (done_b !== 1'b1) begin errors++; $display("FAIL wrap_timeout: got done=%b want 1", done_b); end
        vectors++; if (rdata_b !== 32'h11223344) begin errors++; $display("FAIL wrap_rdata: got %h want 11223344", rdata_b); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_hold();
        test_back_to_back();
        test_reset_mid();
        test_align();
        test_wrap_32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
